in256_out1536_pack: RTL and testbench

// - Width-up packer: gathers 256-bit AXI-Stream beats into one 1536-bit line.
// - Sits directly upstream of the 1536->256 flex down-shifter and drives its s_axis port.
// - Beat k of a line fills bits [256k+255:256k]. Beat 0 therefore lands in the LSBs,

---
 rtl/psys_route_pkg.sv | 17 +
 rtl/in256_out1536_pack.sv | 72 +++++++
 tb/tb_in256_out1536_pack.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/psys_route_pkg.sv
// Shared widths and lane addressing for the 256-bit <-> 1536-bit routing stages.
package psys_route_pkg;

  localparam int IN_W  = 256;
  localparam int RATIO = 6;
  localparam int OUT_W = IN_W * RATIO;
  localparam int CNT_W = 3;

  localparam logic [CNT_W-1:0] CNT_ONE  = 3'd1;
  localparam logic [CNT_W-1:0] CNT_LAST = 3'd5;

  // Low bit of lane idx inside a line; the lane spans [lane_sel(idx) +: IN_W].
  function automatic int lane_sel(input int idx);
    return idx * IN_W;
  endfunction

endpackage

// File: rtl/in256_out1536_pack.sv
// Width-up packer: gathers 256-bit beats into one 1536-bit line, beat 0 in the LSBs,
// with tlast closing a partial line and zero-padding the unfilled lanes.
module in256_out1536_pack
  import psys_route_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [OUT_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  output logic [CNT_W-1:0] m_axis_tbeats,
  input  logic             m_axis_tready
);

  logic [CNT_W-1:0] cnt_r;
  logic [OUT_W-1:0] acc_r;
  logic [OUT_W-1:0] line_s;
  logic             s_fire_s;
  logic             m_fire_s;
  logic             close_s;

  // The output register is the only buffer, so a new beat is taken only if it can drain.
  assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
  assign s_fire_s      = s_axis_tvalid & s_axis_tready;
  assign m_fire_s      = m_axis_tvalid & m_axis_tready;
  assign close_s       = s_fire_s & ((cnt_r == CNT_LAST) | s_axis_tlast);

  // Lane cnt takes the incoming beat, lower lanes keep acc, higher lanes are zero-padded.
  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    localparam logic [CNT_W-1:0] LANE = CNT_W'(k);
    localparam int               LO   = lane_sel(k);
    assign line_s[LO +: IN_W] = (LANE == cnt_r) ? s_axis_tdata :
                                (LANE <  cnt_r) ? acc_r[LO +: IN_W] : {IN_W{1'b0}};
  end

  // Accumulator, beat counter and registered output line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r         <= {CNT_W{1'b0}};
      acc_r         <= {OUT_W{1'b0}};
      m_axis_tdata  <= {OUT_W{1'b0}};
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tbeats <= {CNT_W{1'b0}};
    end else if (close_s) begin
      m_axis_tdata  <= line_s;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= s_axis_tlast;
      m_axis_tbeats <= cnt_r + CNT_ONE;
      cnt_r         <= {CNT_W{1'b0}};
      acc_r         <= {OUT_W{1'b0}};
    end else begin
      if (s_fire_s) begin
        cnt_r <= cnt_r + CNT_ONE;
        acc_r <= line_s;
      end else begin
        cnt_r <= cnt_r;
        acc_r <= acc_r;
      end
      if (m_fire_s) begin
        m_axis_tvalid <= 1'b0;
      end else begin
        m_axis_tvalid <= m_axis_tvalid;
      end
    end
  end

endmodule

// File: tb/tb_in256_out1536_pack.sv
// Self-checking bench: beat-level scoreboard of expected lines, directed cases plus random traffic.
`timescale 1ns/100ps
module tb_in256_out1536_pack;
  import psys_route_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [IN_W-1:0]  s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tlast;
  logic             s_axis_tready;
  logic [OUT_W-1:0] m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic [CNT_W-1:0] m_axis_tbeats;
  logic             m_axis_tready;

  in256_out1536_pack dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tbeats(m_axis_tbeats),
    .m_axis_tready(m_axis_tready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] data;
    int               beats;
    logic             last;
  } line_t;

  line_t           exp_q[$];
  logic [IN_W-1:0] cur_q[$];
  int total = 0;
  int bad   = 0;
  int accepted = 0;
  bit run_cmp = 1'b0;
  logic last_rdy;

  task automatic check(input string name, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, exp);
    end
  endtask

  // Model: a line is just the accepted beats laid out from lane 0 upward, zeros elsewhere.
  task automatic close_line(input logic last);
    line_t ln;
    ln.data  = '0;
    ln.beats = cur_q.size();
    ln.last  = last;
    for (int i = 0; i < cur_q.size(); i++) ln.data[i*IN_W +: IN_W] = cur_q[i];
    exp_q.push_back(ln);
    cur_q.delete();
  endtask

  task automatic drive_cycle(input logic v, input logic [IN_W-1:0] d, input logic l, input logic mr);
    bit ev, er;
    line_t dummy;
    @(negedge clk);
    #2;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    m_axis_tready = mr;
    #1;
    ev = (exp_q.size() != 0);
    er = !ev || mr;
    last_rdy = s_axis_tready;
    check("s_tready", {255'd0, s_axis_tready}, {255'd0, er});
    if (ev && mr) dummy = exp_q.pop_front();
    if (v && er) begin
      cur_q.push_back(d);
      accepted++;
      if (cur_q.size() == RATIO || l) close_line(l);
    end
  endtask

  function automatic logic [IN_W-1:0] rand_beat();
    logic [IN_W-1:0] r;
    for (int i = 0; i < IN_W/32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Every cycle the output register must show exactly the head of the expected-line queue.
  always @(negedge clk) begin
    if (run_cmp && rst_n) begin
      check("m_tvalid", {255'd0, m_axis_tvalid}, {255'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        for (int k = 0; k < RATIO; k++)
          check($sformatf("lane%0d", k), m_axis_tdata[k*IN_W +: IN_W], exp_q[0].data[k*IN_W +: IN_W]);
        check("m_tbeats", {253'd0, m_axis_tbeats}, IN_W'(exp_q[0].beats));
        check("m_tlast", {255'd0, m_axis_tlast}, {255'd0, exp_q[0].last});
      end
    end
  end

  initial begin
    int rdy_zero;
    int vcnt;
    int cyc;
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    #12;
    check("rst_tvalid", {255'd0, m_axis_tvalid}, 256'd0);
    check("rst_tlast", {255'd0, m_axis_tlast}, 256'd0);
    check("rst_tbeats", {253'd0, m_axis_tbeats}, 256'd0);
    check("rst_lane0", m_axis_tdata[255:0], 256'd0);
    check("rst_tready", {255'd0, s_axis_tready}, 256'd1);
    rst_n = 1'b1;
    run_cmp = 1'b1;

    // T1: full line with tlast on the sixth beat
    for (int k = 0; k < RATIO; k++) drive_cycle(1'b1, IN_W'(k + 1), k == RATIO - 1, 1'b1);
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    check("t1_valid", {255'd0, m_axis_tvalid}, 256'd1);
    check("t1_lane0", m_axis_tdata[255:0], 256'h1);
    check("t1_lane5", m_axis_tdata[1535:1280], 256'h6);
    check("t1_beats", {253'd0, m_axis_tbeats}, 256'd6);
    check("t1_last", {255'd0, m_axis_tlast}, 256'd1);

    // T2: line held under backpressure, input stalled, then released
    for (int k = 0; k < RATIO; k++) drive_cycle(1'b1, IN_W'(16'h20 + k), 1'b0, 1'b0);
    rdy_zero = 0;
    for (int k = 0; k < 10; k++) begin
      drive_cycle(1'b1, IN_W'(16'hDEAD), 1'b0, 1'b0);
      if (!last_rdy) rdy_zero++;
    end
    check("t2_stall_cycles", IN_W'(rdy_zero), 256'd10);
    check("t2_held_lane3", m_axis_tdata[1023:768], 256'h23);
    for (int k = 0; k < RATIO; k++) drive_cycle(1'b1, IN_W'(16'h30 + k), 1'b0, 1'b1);
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    check("t2_next_lane0", m_axis_tdata[255:0], 256'h30);
    check("t2_next_last", {255'd0, m_axis_tlast}, 256'd0);

    // T3: short packet of two beats
    drive_cycle(1'b1, 256'hA, 1'b0, 1'b1);
    drive_cycle(1'b1, 256'hB, 1'b1, 1'b1);
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    check("t3_lane0", m_axis_tdata[255:0], 256'hA);
    check("t3_lane1", m_axis_tdata[511:256], 256'hB);
    check("t3_lane2", m_axis_tdata[767:512], 256'h0);
    check("t3_lane5", m_axis_tdata[1535:1280], 256'h0);
    check("t3_beats", {253'd0, m_axis_tbeats}, 256'd2);
    check("t3_last", {255'd0, m_axis_tlast}, 256'd1);
    drive_cycle(1'b0, '0, 1'b0, 1'b1);

    // T4: 60 back-to-back beats
    rdy_zero = 0;
    vcnt = 0;
    for (int k = 0; k < 61; k++) begin
      if (k < 60) drive_cycle(1'b1, rand_beat(), 1'b0, 1'b1);
      else        drive_cycle(1'b0, '0, 1'b0, 1'b1);
      if (!last_rdy) rdy_zero++;
      if (m_axis_tvalid) vcnt++;
    end
    check("t4_rdy_drops", IN_W'(rdy_zero), 256'd0);
    check("t4_lines", IN_W'(vcnt), 256'd10);

    // T5: reset with a partial line in flight
    for (int k = 0; k < 3; k++) drive_cycle(1'b1, IN_W'(16'h50 + k), 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    exp_q.delete();
    cur_q.delete();
    #2;
    check("t5_rst_valid", {255'd0, m_axis_tvalid}, 256'd0);
    rst_n = 1'b1;
    for (int k = 0; k < RATIO; k++) drive_cycle(1'b1, IN_W'(16'hF0 + k), k == RATIO - 1, 1'b1);
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    check("t5_lane0", m_axis_tdata[255:0], 256'hF0);
    check("t5_lane2", m_axis_tdata[767:512], 256'hF2);
    check("t5_beats", {253'd0, m_axis_tbeats}, 256'd6);

    // T6: random valid/ready/last over 10k beats
    accepted = 0;
    cyc = 0;
    while (accepted < 10000 && cyc < 40000) begin
      drive_cycle($urandom_range(99) < 70, rand_beat(), $urandom_range(99) < 15,
                  $urandom_range(99) < 70);
      cyc++;
    end
    check("t6_budget", IN_W'(accepted >= 10000), 256'd1);
    drive_cycle(1'b1, rand_beat(), 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) drive_cycle(1'b0, '0, 1'b0, 1'b1);
    check("t6_drained", IN_W'(exp_q.size()), 256'd0);
    check("t6_out_idle", {255'd0, m_axis_tvalid}, 256'd0);

    run_cmp = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
